// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter.
//   Contents:
//     state_t        - converter FSM state encoding
//     BCD_BLANK      - nibble shown in place of a blanked leading-zero digit
//     digits_needed  - decimal digits needed to hold any BIN_W-bit value
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // ceil(bin_w * log10(2)), using log10(2) ~= 0.30103 in fixed point.
  // The constant is rounded up, so the result is never too small; at worst
  // the scratch register carries one spare (always-zero) digit.
  function automatic int digits_needed(input int bin_w);
    int n;
    n = (bin_w * 30103 + 99999) / 100000;
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Double-dabble digit adjust: a BCD digit of 5 or more gets 3 added so
//   that the following left shift carries correctly into the next digit.
//   Ports:
//     din  - scratch digit before adjust
//     dout - adjusted digit
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// seq_bin_to_bcd
//   Sequential binary-to-BCD converter, one bit per clock (double-dabble).
//   Optional feature macro: BCD_BLANK_EN -- leading-zero digits of the
//   result read as BCD_BLANK (4'hF); digit 0 is never blanked and a
//   saturated (overflow) result is never blanked.
//
//   Parameters:
//     BIN_W  - binary input width (>= 4)
//     DIGITS - number of BCD output digits (>= 1)
//   Ports:
//     clk       - clock, rising edge
//     rst_n     - asynchronous active-low reset
//     start     - conversion request, only honoured in IDLE
//     bin       - unsigned input, captured when start is accepted
//     busy      - high from the accepting edge until the converter is
//                 back in IDLE (covers SHIFT and DONE)
//     done      - one-cycle pulse; bcd/ovf are valid from this cycle on
//     bcd       - packed result, digit 0 (ones) in bits [3:0]
//     ovf       - result did not fit in DIGITS digits (bcd reads all 9s)
//     dbg_state - current FSM state, for observation only
//
//   Handshake: start is a request without acknowledge; it is accepted on a
//   rising edge where the FSM is in IDLE and dropped silently otherwise.
//   Timing: start accepted at edge k, eleven-ish shift edges k+1..k+BIN_W,
//   result registered and done raised at edge k+BIN_W+1, FSM back in IDLE
//   at edge k+BIN_W+2.
// -----------------------------------------------------------------------------
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output state_t              dbg_state
);

  // Scratch holds every digit the input can produce, and at least DIGITS
  // so the low DIGITS digits can always be sliced out directly.
  localparam int DN  = digits_needed(BIN_W);
  localparam int SCR = (DN > DIGITS) ? DN : DIGITS;
  localparam int SW  = 4 * SCR;
  localparam int CW  = $clog2(BIN_W + 1);

  state_t                state;
  logic [SW-1:0]         scratch;
  logic [SW-1:0]         adj;
  logic [BIN_W-1:0]      shreg;
  logic [CW-1:0]         cnt;
  logic [SW+BIN_W-1:0]   shifted;
  logic [4*DIGITS-1:0]   bcd_load;
  logic                  ovf_load;

  // One add-3 cell per scratch digit.
  for (genvar g = 0; g < SCR; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Adjusted scratch and remaining input bits shift left as one register.
  assign shifted = {adj, shreg} << 1;

  // Any nonzero digit beyond the visible ones means the value does not fit.
  always_comb begin
    ovf_load = 1'b0;
    for (int i = DIGITS; i < SCR; i++) begin
      if (scratch[4*i +: 4] != 4'd0) ovf_load = 1'b1;
    end
  end

  // Value presented at the DONE load: saturated, or numeric (optionally
  // with leading zeros blanked, scanning down from the top digit).
  always_comb begin
`ifdef BCD_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    bcd_load = scratch[4*DIGITS-1:0];
    if (ovf_load) begin
      for (int i = 0; i < DIGITS; i++) bcd_load[4*i +: 4] = 4'd9;
    end else begin
`ifdef BCD_BLANK_EN
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (scratch[4*i +: 4] == 4'd0)) bcd_load[4*i +: 4] = BCD_BLANK;
        else lead = 1'b0;
      end
`endif
    end
  end

  // DONE spans two cycles: the first loads the result, the second shows
  // done=1 while still busy, so a start during the done pulse is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      scratch <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CW'(BIN_W);
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= shifted[SW+BIN_W-1:BIN_W];
          shreg   <= shifted[BIN_W-1:0];
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!done) begin
            bcd  <= bcd_load;
            ovf  <= ovf_load;
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/seq_bin_to_bcd.md
SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 SHALL have parameter BIN_W, default 11, binary input width (>=4).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port bin  input  BIN_W  unsigned value, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse; bcd/ovf valid from this cycle.
REQ-009 SHALL have port bcd  output  4*DIGITS  packed digits, digit 0 (ones) in bits [3:0].
REQ-010 SHALL have port ovf  output  1  result exceeded 10^DIGITS-1.

Function
REQ-011 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-012 IDLE with start=1: SHALL capture bin, clear scratch BCD register, load counter with BIN_W, go to SHIFT.
REQ-013 SHIFT: per cycle, SHALL add 3 to every scratch digit >=5, then left-shift {scratch, bin_shreg} by one bit (double-dabble); counter decrements.
REQ-014 SHALL leave SHIFT after exactly BIN_W cycles; total latency is BIN_W+1 cycles from the start edge to done=1.
REQ-015 DONE: SHALL register bcd and ovf, assert done for exactly one cycle, return to IDLE.
REQ-016 Scratch register SHALL be wide enough for ceil(BIN_W*log10(2)) digits; any nonzero digit above DIGITS-1 sets ovf=1.
REQ-017 When ovf=1, bcd SHALL saturate to all digits 9.
REQ-018 start while busy=1 SHALL be ignored, with no queuing; bin changes during conversion SHALL have no effect.
REQ-019 start in the same cycle as done SHALL be ignored; it is accepted from the following IDLE cycle.
REQ-020 bcd and ovf SHALL hold their last value until the next DONE cycle.
REQ-021 bin=0 SHALL complete normally, giving bcd all zeros and ovf=0.

Reset
REQ-022 rst_n low SHALL immediately force IDLE with busy=0, done=0, bcd=0, ovf=0, counter=0 and scratch=0.
REQ-023 Reset mid-conversion SHALL abort the conversion; no done is issued, and the first start after release is accepted normally.

Configuration
REQ-024 With macro BCD_BLANK_EN defined, leading-zero digits in bcd (all digits above the most significant nonzero digit) SHALL read 4'hF; digit 0 is never blanked.
REQ-025 Without BCD_BLANK_EN, every digit SHALL be output numerically, including leading zeros.
REQ-026 Blanking SHALL apply in the DONE register load only; latency is unchanged and a saturated (ovf) result has no blanking.

Structure
REQ-027 Shared package bcd_pkg SHALL hold the FSM state typedef, the BCD_BLANK nibble constant (4'hF) and a digits-needed function of BIN_W.
REQ-028 Per-digit add-3 adjust SHALL be a sub-module bcd_add3 (4-bit in, 4-bit out, combinational), instantiated once per scratch digit.

Verification
REQ-029 Scenario (default parameters): start with bin=0 -> done 12 cycles later, bcd=16'h0000, ovf=0.
REQ-030 Scenario (default parameters): sweep bin 0..2047 one conversion each -> bcd equals the decimal digits (e.g. 2047 -> 16'h2047, 1234 -> 16'h1234), ovf=0.
REQ-031 Scenario (DIGITS=3): bin=1000 -> bcd=12'h999, ovf=1; bin=999 -> 12'h999, ovf=0.
REQ-032 Scenario: bin=5, start; at cycle 4 change bin to 9 and pulse start -> single done with bcd=16'h0005.
REQ-033 Scenario: rst_n low at cycle 6 of a conversion -> no done, all outputs 0; next start with bin=42 -> 16'h0042.
REQ-034 Scenario (BCD_BLANK_EN defined): bin=7 -> 16'hFFF7; bin=0 -> 16'hFFF0; bin=1005 -> 16'h1005.
